clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock/tick divider for the game's slow-rate timing: animation frames, sprite movement, blink and debounce rates. It replaces single-purpose fixed-divisor dividers with one bank of CH independent channels. Each channel has a run-time loadable half-period, a glitch-free divisor update, an enable, and a synchronous restart. It sits next to the top level, fed by the board clock, and drives the rate inputs of the game logic.

## Interface
- `CH`, 4, number of independent channels (1..16).
- `CW`, 32, counter and half-period width in bits.
- `DEF_HALF`, 10_000_000, half-period loaded into every channel at reset.
- `clk` in 1: board clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in CH: per-channel count enable.
- `restart` in CH: per-channel synchronous restart strobe.
- `ld` in 1: divisor load strobe, one cycle.
- `ld_ch` in max(1,$clog2(CH)): target channel of `ld`.
- `ld_half` in CW: new half-period for `ld_ch`.
- `clk_out` out CH: divided square wave per channel.
- `tick` out CH: one-cycle pulse at each `clk_out` edge.
- `pend` out CH: a loaded half-period is waiting to be applied.

## Operation
- Per channel registers: `cnt`[CW], `half`[CW] (active), `nxt`[CW] (pending), `pend`, `clk_out`, `tick`.
- Reset values:
  - `cnt`=0, `half`=`nxt`=DEF_HALF.
  - `clk_out`=0, `tick`=0, `pend`=0.
- Count, when `en` is high and `restart` is low:
  - if `cnt`<`half`: `cnt`+1.
  - else (terminal count): `cnt`←0, `clk_out` toggles, `tick`←1.
  - If `pend` is set at terminal count, `half`←`nxt` and `pend`←0.
- Periods: toggle every `half`+1 enabled cycles; `clk_out` period is 2·(`half`+1). `half`=0 makes `clk_out` toggle every cycle, giving clk/2.
- `en` low: `cnt`, `clk_out`, `half` hold; `tick`=0; pending stays pending.
- `restart` high, regardless of `en`:
  - `cnt`←0, `clk_out`←0, `tick`←0.
  - If `pend` is set, `half`←`nxt` and `pend`←0.
- Load, `ld` high with `ld_ch`<CH: `nxt[ld_ch]`←`ld_half`, `pend[ld_ch]`←1. `ld_ch`≥CH is ignored with no state change.
- Load again while pending: overwrites `nxt`; only the last value is applied.
- Simultaneous events on one channel:
  - `ld` + `restart`: the loaded value goes straight to `half`; `pend` ends 0.
  - `ld` + terminal count: the terminal count applies the old `nxt` if `pend` was set. The new value becomes pending (`pend`=1) for the next terminal count.
- Shrinking `half` never truncates a half-cycle, since it only takes effect at terminal count or restart. No runt pulses on `clk_out`.
- Counter comparison is unsigned, with no overflow because `cnt`≤`half`.

## Timing
- All outputs are registered; no combinational input-to-output path.
- From `rst` release with `en` held high, the first `clk_out` rise is on rising edge HALF+1. `tick` is high in the cycle following that edge only.
- `tick` and the `clk_out` transition appear in the same cycle.
- `ld` is seen by `pend` one edge later.
- `restart` takes effect on the next edge; the first toggle after restart follows `half`+1 enabled edges.
- `rst` mid-operation clears all channels immediately and discards pending loads.

## Configuration
- `CLK_DIV_BANK_TICK_EN` defined: `tick` behaves as above.
- `CLK_DIV_BANK_TICK_EN` undefined: `tick` is constant 0 and its registers are not built; `clk_out` is unaffected.

## Structure
- Package `clk_div_pkg`:
  - default CH, CW, DEF_HALF.
  - named half-period constants for the game rates, e.g. `HALF_240MS`.
  - a typedef for the half-period word.
- Sub-module `clk_div_chan`: one channel holding `cnt`, `half`, `nxt`, `pend`, `clk_out`, `tick`.
- `clk_div_bank` instantiates `clk_div_chan` CH times in a generate loop and decodes `ld_ch` into per-channel load strobes.

## Test plan
- Reset, DEF_HALF=3, `en`=all 1 → `clk_out[0]` rises at edge 4 and falls at edge 8; `tick` is high one cycle at each.
- Ch1 running with `half`=5; load 1 at `cnt`=2 → `pend[1]`=1 until terminal count (`cnt`=5). Next half-cycles are 2 cycles long; no truncated half-cycle.
- `en[2]` low for 10 cycles mid-count → `cnt`/`clk_out` frozen, `tick[2]`=0; counting resumes from the frozen value.
- `restart[0]` and `ld`(ch 0, half=7) in the same cycle → `clk_out[0]`=0, `pend[0]`=0; next toggle after 8 cycles.
- `ld` with `ld_ch`=CH (out of range) → no `pend` change on any channel. Then assert `rst` mid-count → all outputs return to reset values within the reset assertion.
- Build without `CLK_DIV_BANK_TICK_EN` → `tick`≡0 and `clk_out` waveforms are identical to the first scenario.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the slow-rate clock/tick divider bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default bank geometry, half-period word type, named game-rate
// half-periods computed for a 50 MHz board clock, and the helper that derives them.
package clk_div_pkg;

    localparam int DEFAULT_CH = 4;
    localparam int DEFAULT_CW = 32;

    typedef logic [DEFAULT_CW-1:0] half_t;

    localparam half_t DEFAULT_HALF = 32'd10_000_000;

    // Board clock the named rates below are computed for.
    localparam int unsigned CLK_MHZ = 50;

    // A full output period of period_us spans 2*(half+1) input cycles.
    function automatic half_t half_from_period_us(input int unsigned period_us);
        longint unsigned cycles;
        cycles = 64'(period_us) * 64'(CLK_MHZ) / 64'd2;
        return half_t'(cycles - 64'd1);
    endfunction

    localparam half_t HALF_1S    = half_from_period_us(1_000_000); // blink
    localparam half_t HALF_500MS = half_from_period_us(500_000);   // fast blink
    localparam half_t HALF_240MS = half_from_period_us(240_000);   // animation frame
    localparam half_t HALF_40MS  = half_from_period_us(40_000);    // sprite step
    localparam half_t HALF_20MS  = half_from_period_us(20_000);    // debounce sample

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: square wave toggling every half+1 enabled cycles, plus edge tick.
// Latency: all outputs registered; ld reaches pend one edge later, restart acts on next edge.
// Backpressure: none; en freezes the channel, no handshake.
// Ports: clk, rst (async, active-high), en, restart, ld/ld_half (pending divisor load),
//        clk_out, tick, pend. Macro CLK_DIV_BANK_TICK_EN builds the tick register;
//        without it tick is tied to 0.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int            CW       = DEFAULT_CW,
    parameter logic [CW-1:0] DEF_HALF = CW'(DEFAULT_HALF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic          ld,
    input  logic [CW-1:0] ld_half,
    output logic          clk_out,
    output logic          tick,
    output logic          pend
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] half;
    logic [CW-1:0] nxt;
    logic          term;

    // cnt never exceeds half, so this is the terminal-count condition.
    assign term = (cnt >= half);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            half    <= DEF_HALF;
            nxt     <= DEF_HALF;
            pend    <= 1'b0;
            clk_out <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            // A load coinciding with restart bypasses the pending stage.
            if (ld) begin
                half <= ld_half;
                nxt  <= ld_half;
                pend <= 1'b0;
            end else if (pend) begin
                half <= nxt;
                pend <= 1'b0;
            end
        end else begin
            if (en) begin
                if (!term) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    // Divisor swaps only on a half-cycle boundary: no runt pulses.
                    if (pend) begin
                        half <= nxt;
                        pend <= 1'b0;
                    end
                end
            end
            // A fresh load wins over the clear above and waits for the next terminal count.
            if (ld) begin
                nxt  <= ld_half;
                pend <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_BANK_TICK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= en && !restart && term;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CH independent programmable clock/tick dividers for slow game rates.
// Latency: outputs registered; ld -> pend one edge, restart effective next edge.
// Backpressure: none; per-channel en freezes counting, loads are fire-and-forget.
// Ports: clk, rst (async, active-high), en[CH], restart[CH], ld, ld_ch, ld_half,
//        clk_out[CH], tick[CH], pend[CH]. ld_ch >= CH is ignored.
//        Macro CLK_DIV_BANK_TICK_EN enables tick generation (tick is 0 otherwise).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int            CH       = DEFAULT_CH,
    parameter int            CW       = DEFAULT_CW,
    parameter logic [CW-1:0] DEF_HALF = CW'(DEFAULT_HALF)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CH-1:0]                        en,
    input  logic [CH-1:0]                        restart,
    input  logic                                 ld,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] ld_ch,
    input  logic [CW-1:0]                        ld_half,
    output logic [CH-1:0]                        clk_out,
    output logic [CH-1:0]                        tick,
    output logic [CH-1:0]                        pend
);

    localparam int LW = (CH > 1) ? $clog2(CH) : 1;

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_chan
            // Out-of-range ld_ch values match no channel and are dropped.
            logic ld_hit;
            assign ld_hit = ld && (ld_ch == LW'(i));

            clk_div_chan #(
                .CW       (CW),
                .DEF_HALF (DEF_HALF)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .en      (en[i]),
                .restart (restart[i]),
                .ld      (ld_hit),
                .ld_half (ld_half),
                .clk_out (clk_out[i]),
                .tick    (tick[i]),
                .pend    (pend[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    localparam int CH = 3;
    localparam int CW = 16;
    localparam int LW = 2;

`ifdef CLK_DIV_BANK_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic [CH-1:0] restart;
    logic          ld;
    logic [LW-1:0] ld_ch;
    logic [CW-1:0] ld_half;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] pend;

    clk_div_bank #(
        .CH       (CH),
        .CW       (CW),
        .DEF_HALF (16'd3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .restart (restart),
        .ld      (ld),
        .ld_ch   (ld_ch),
        .ld_half (ld_half),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    // kind: 0 = clk_out, 1 = tick, 2 = pend
    typedef struct {
        int    cyc;
        int    ch;
        int    kind;
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    int   base;

    function automatic void push(int c, int ch, int kind, logic v, string tag);
        exp_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        e.val  = v;
        e.tag  = tag;
        sb.push_back(e);
    endfunction

    // Expected square wave from a channel whose counter is 0 at cycle base
    // with clk_out = c0 and half-period h: toggles every h+1 cycles.
    function automatic void wave(int ch, int b, int h, logic c0, int kf, int kt, string tag);
        for (int k = kf; k <= kt; k++) begin
            push(b + k, ch, 0, c0 ^ (((k / (h + 1)) % 2) == 1), tag);
            push(b + k, ch, 1, TICK_ON && (k > 0) && ((k % (h + 1)) == 0), tag);
        end
    endfunction

    function automatic void all_zero(int c, string tag);
        for (int ch = 0; ch < CH; ch++) begin
            push(c, ch, 0, 1'b0, tag);
            push(c, ch, 1, 1'b0, tag);
            push(c, ch, 2, 1'b0, tag);
        end
    endfunction

    task automatic check_due();
        exp_t e;
        logic got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                e = sb[i];
                case (e.kind)
                    0:       got = clk_out[e.ch];
                    1:       got = tick[e.ch];
                    default: got = pend[e.ch];
                endcase
                checks++;
                assert (got === e.val) else begin
                    errors++;
                    $error("FAIL %s ch%0d kind%0d cyc%0d got=%b exp=%b",
                           e.tag, e.ch, e.kind, cyc, got, e.val);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    initial begin
        rst     = 1'b1;
        en      = '0;
        restart = '0;
        ld      = 1'b0;
        ld_ch   = '0;
        ld_half = '0;
        cyc     = 0;

        // Reset state
        repeat (2) step();
        all_zero(cyc, "reset");
        check_due();

        // Scenario 1: DEF_HALF=3 -> rise at edge 4, fall at edge 8
        rst = 1'b0;
        en  = '1;
        cyc = 0;
        wave(0, 0, 3, 1'b0, 1, 16, "s1_ch0");
        wave(1, 0, 3, 1'b0, 1, 16, "s1_ch1");
        repeat (16) step();

        // Scenario 2: ch1 restart+load 5, then load 1 at cnt=2
        restart = 3'b010;
        ld      = 1'b1;
        ld_ch   = 2'd1;
        ld_half = 16'd5;
        wave(1, 17, 5, 1'b0, 0, 6, "s2_a");
        wave(1, 23, 1, 1'b1, 1, 6, "s2_b");
        for (int c = 17; c <= 29; c++)
            push(c, 1, 2, (c >= 20 && c <= 22), "s2_pend");
        step();                     // 17
        restart = '0;
        ld      = 1'b0;
        repeat (2) step();          // 19, cnt=2
        ld      = 1'b1;
        ld_half = 16'd1;
        step();                     // 20
        ld      = 1'b0;
        repeat (10) step();         // 30

        // Scenario 3: en[2] low for 10 cycles (ch2 at cnt=2, clk_out=1)
        for (int c = 31; c <= 40; c++) begin
            push(c, 2, 0, 1'b1, "s3_frozen");
            push(c, 2, 1, 1'b0, "s3_frozen");
        end
        wave(2, 10, 3, 1'b0, 31, 38, "s3_resume");
        en = 3'b011;
        repeat (10) step();         // 40
        en = '1;
        repeat (8) step();          // 48

        // Scenario 4: restart[0] with load 7 on ch0 in the same cycle
        restart = 3'b001;
        ld      = 1'b1;
        ld_ch   = 2'd0;
        ld_half = 16'd7;
        push(49, 0, 2, 1'b0, "s4_pend");
        push(50, 0, 2, 1'b0, "s4_pend");
        wave(0, 49, 7, 1'b0, 0, 20, "s4_ch0");
        step();                     // 49
        restart = '0;
        ld      = 1'b0;
        repeat (10) step();         // 59

        // Scenario 5: out-of-range ld_ch
        ld      = 1'b1;
        ld_ch   = 2'd3;
        ld_half = 16'd0;
        for (int ch = 0; ch < CH; ch++) begin
            push(60, ch, 2, 1'b0, "s5_oor");
            push(61, ch, 2, 1'b0, "s5_oor");
        end
        step();                     // 60
        ld = 1'b0;
        repeat (9) step();          // 69

        // Pending load on ch2, then asynchronous reset mid-count
        ld      = 1'b1;
        ld_ch   = 2'd2;
        ld_half = 16'd9;
        push(70, 2, 2, 1'b1, "pre_rst_pend");
        step();                     // 70
        ld = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        all_zero(cyc, "rst_async");
        check_due();
        all_zero(72, "rst_hold");
        repeat (2) step();          // 72
        rst  = 1'b0;
        base = cyc;
        wave(0, base, 3, 1'b0, 1, 8, "post_rst_ch0");
        wave(2, base, 3, 1'b0, 1, 8, "post_rst_ch2");
        for (int k = 1; k <= 8; k++)
            push(base + k, 2, 2, 1'b0, "post_rst_pend");
        repeat (8) step();

        // Any expectation never reached is a failure
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL unchecked %s ch%0d kind%0d due cyc%0d got=none exp=%b",
                   sb[0].tag, sb[0].ch, sb[0].kind, sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
